mem_access_m: RTL and testbench

- Memory-stage load/store unit of the combined ARM/RISC-V pipeline.
- Consumes the execute-stage memory outputs: address (ALUResultE), store data, write/read strobes, size and signedness.
- Drives a request/grant/response data-memory bus with byte-lane alignment, and returns sign- or zero-extended load data.
- Holds the pipeline via MemBusyM while an access is in flight; flags misaligned accesses and timeouts.

---
 rtl/combi_mem_pkg.sv | 44 ++++
 rtl/mem_lane.sv | 45 ++++
 rtl/mem_access_m.sv | 165 ++++++++++++++++
 tb/tb_mem_access_m.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combi_mem_pkg.sv
// Shared definitions for the memory-stage load/store path.
// Holds the access-size and FSM state encodings, plus the alignment and
// byte-enable helpers used by both the FSM and the lane logic.
package combi_mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } mem_state_t;

  // The unused size code 2'b11 behaves exactly like a word access.
  function automatic mem_size_t decode_size(input logic [1:0] code);
    case (code)
      2'b00:   return MEM_B;
      2'b01:   return MEM_H;
      default: return MEM_W;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] off, input mem_size_t size);
    case (size)
      MEM_H:   return off[0];
      MEM_W:   return (off != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] off, input mem_size_t size);
    case (size)
      MEM_B:   return 4'b0001 << off;
      MEM_H:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for little-endian data memory accesses.
// Store side: byte enables and lane-replicated write data.
// Load side: shifts the addressed bytes down and sign/zero extends them.
// Ports:
//   i_st_offset, i_st_size, i_st_wdata -> o_be, o_wdata
//   i_ld_offset, i_ld_size, i_ld_signed, i_ld_rdata -> o_rdata
import combi_mem_pkg::*;

module mem_lane (
  input  logic [1:0]  i_st_offset,
  input  mem_size_t   i_st_size,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ld_offset,
  input  mem_size_t   i_ld_size,
  input  logic        i_ld_signed,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_rdata
);

  // Only the low halfword of the shifted word is ever extracted.
  logic [15:0] w_ldShift;
  assign w_ldShift = 16'(i_ld_rdata >> {i_ld_offset, 3'b000});

  // Replicating the store data across lanes lets the byte enables alone
  // select which bytes memory actually writes.
  always_comb begin
    o_be = byte_enable(i_st_offset, i_st_size);
    case (i_st_size)
      MEM_B:   o_wdata = {4{i_st_wdata[7:0]}};
      MEM_H:   o_wdata = {2{i_st_wdata[15:0]}};
      default: o_wdata = i_st_wdata;
    endcase
  end

  always_comb begin
    case (i_ld_size)
      MEM_B:   o_rdata = {{24{i_ld_signed & w_ldShift[7]}}, w_ldShift[7:0]};
      MEM_H:   o_rdata = {{16{i_ld_signed & w_ldShift[15]}}, w_ldShift};
      default: o_rdata = i_ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_m.sv
// Memory-stage load/store unit.
// Captures an execute-stage access, runs it over a req/gnt/rvalid data-memory
// bus and returns extended load data. MemBusyM stalls the pipeline while the
// access is in flight. Misaligned accesses and bus timeouts retire with MemErrM.
// Ports:
//   clk, rst (async, active low)
//   ALUResultE, WriteDataE, MemWriteE, MemReadE, MemSizeE, MemSignedE : request
//   MemBusyM, MemDoneM, MemErrM, ReadDataM                            : status/data
//   dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata                 : bus out
//   dmem_gnt, dmem_rvalid, dmem_rdata                                 : bus in
import combi_mem_pkg::*;

module mem_access_m #(
  parameter int MAX_WAIT = 16,
  parameter int WAIT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic        MemWriteE,
  input  logic        MemReadE,
  input  logic [1:0]  MemSizeE,
  input  logic        MemSignedE,
  output logic        MemBusyM,
  output logic        MemDoneM,
  output logic        MemErrM,
  output logic [31:0] ReadDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  mem_state_t        r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_we;
  logic [1:0]        r_off;
  mem_size_t         r_size;
  logic              r_signed;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic              r_req;
  logic [31:0]       r_addr;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;

  mem_size_t   w_sizeE;
  logic        w_misE;
  logic        w_accept;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata;

  assign w_sizeE   = decode_size(MemSizeE);
  assign w_misE    = misaligned(ALUResultE[1:0], w_sizeE);
  assign w_accept  = ((r_state == IDLE) || (r_state == DONE)) && (MemReadE || MemWriteE);
  // Counter value of the last allowed wait cycle: the MAX_WAIT-th cycle spent
  // in REQ or RESP without the awaited handshake aborts the access.
  assign w_timeout = (r_wait == WAIT_W'(MAX_WAIT - 1));

  // Store lanes come straight from the execute-stage inputs so they can be
  // registered at capture; load extraction uses the captured offset/size.
  mem_lane u_lane (
    .i_st_offset (ALUResultE[1:0]),
    .i_st_size   (w_sizeE),
    .i_st_wdata  (WriteDataE),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .i_ld_offset (r_off),
    .i_ld_size   (r_size),
    .i_ld_signed (r_signed),
    .i_ld_rdata  (dmem_rdata),
    .o_rdata     (w_rdata)
  );

  // Access sequencer. DONE behaves like IDLE for acceptance so back-to-back
  // accesses retire without a bubble. Handshakes take priority over timeout
  // when both land in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_wait   <= '0;
      r_we     <= 1'b0;
      r_off    <= 2'b00;
      r_size   <= MEM_B;
      r_signed <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_we     <= MemWriteE;
            r_off    <= ALUResultE[1:0];
            r_size   <= w_sizeE;
            r_signed <= MemSignedE;
            r_addr   <= {ALUResultE[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_rdata  <= '0;
            r_wait   <= '0;
            if (w_misE) begin
              r_state <= DONE;
              r_err   <= 1'b1;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        REQ: begin
          if (dmem_gnt) begin
            r_req   <= 1'b0;
            r_wait  <= '0;
            r_state <= r_we ? DONE : RESP;
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= DONE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            r_rdata <= w_rdata;
            r_state <= DONE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= DONE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MemBusyM   = (r_state == REQ) || (r_state == RESP);
  assign MemDoneM   = (r_state == DONE);
  assign MemErrM    = r_err;
  assign ReadDataM  = r_rdata;
  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_be    = r_be;
  assign dmem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access_m.sv
// Self-checking bench for mem_access_m: directed cases for the called-out
// corners plus randomized accesses against a transaction-level model.
module tb_mem_access_m;

  localparam int MAX_WAIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ALUResultE = '0;
  logic [31:0] WriteDataE = '0;
  logic        MemWriteE = 1'b0;
  logic        MemReadE = 1'b0;
  logic [1:0]  MemSizeE = 2'b00;
  logic        MemSignedE = 1'b0;
  logic        MemBusyM;
  logic        MemDoneM;
  logic        MemErrM;
  logic [31:0] ReadDataM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_access_m #(.MAX_WAIT(MAX_WAIT), .WAIT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .ALUResultE  (ALUResultE),
    .WriteDataE  (WriteDataE),
    .MemWriteE   (MemWriteE),
    .MemReadE    (MemReadE),
    .MemSizeE    (MemSizeE),
    .MemSignedE  (MemSignedE),
    .MemBusyM    (MemBusyM),
    .MemDoneM    (MemDoneM),
    .MemErrM     (MemErrM),
    .ReadDataM   (ReadDataM),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One access: the bench acts as the memory, granting after gd REQ cycles
  // and returning data rd cycles after the grant. Expectations come from the
  // access rules in plain arithmetic, not from the DUT.
  task automatic applyStimulus(input bit isWr, input bit alsoRd, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [1:0] sz, input bit sgn,
                               input int gd, input int rd, input logic [31:0] word);
    int nb;
    int off;
    int expCyc;
    int doneCyc;
    int reqCnt;
    int respCnt;
    bit mis;
    bit expErr;
    bit gnted;
    bit reqSeen;
    bit busyBad;
    logic [31:0] expBe;
    logic [31:0] expWd;
    logic [31:0] expRd;
    logic [31:0] mask;
    logic [31:0] val;
    logic gotErr;
    logic gotBusy;
    logic gotReq;
    logic [31:0] gotRd;

    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = int'(addr % 4);
    mis = (int'(addr % 32'(nb)) != 0);
    expBe = 32'(((1 << nb) - 1) << off);
    expWd = (nb == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
            (nb == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    val  = (word >> (8 * off)) & mask;
    if (nb < 4 && sgn && val[8*nb-1]) val = val | ~mask;
    expRd = val;

    if (mis) begin
      expErr = 1; expCyc = 1;
    end else if (gd >= MAX_WAIT) begin
      expErr = 1; expCyc = MAX_WAIT + 1;
    end else if (isWr) begin
      expErr = 0; expCyc = gd + 2;
    end else if (rd <= MAX_WAIT) begin
      expErr = 0; expCyc = gd + rd + 2;
    end else begin
      expErr = 1; expCyc = gd + MAX_WAIT + 2;
    end
    if (expErr) expRd = 0;

    @(negedge clk);
    MemWriteE  = isWr;
    MemReadE   = !isWr || alsoRd;
    ALUResultE = addr;
    WriteDataE = wd;
    MemSizeE   = sz;
    MemSignedE = sgn;
    dmem_rdata = word;
    @(negedge clk);
    MemWriteE = 1'b0;
    MemReadE  = 1'b0;

    doneCyc = 0; reqCnt = 0; respCnt = 0; gnted = 0; reqSeen = 0; busyBad = 0;
    gotErr = 0; gotBusy = 1; gotReq = 1; gotRd = 32'hDEAD_DEAD;
    for (int c = 1; c <= 60; c++) begin
      if (MemDoneM) begin
        doneCyc = c; gotErr = MemErrM; gotBusy = MemBusyM; gotReq = dmem_req; gotRd = ReadDataM;
        break;
      end
      if (!MemBusyM) busyBad = 1;
      if (dmem_req && !reqSeen) begin
        reqSeen = 1;
        checkOutput("bus_addr", dmem_addr, {addr[31:2], 2'b00});
        checkOutput("bus_be", {28'd0, dmem_be}, expBe);
        checkOutput("bus_we", {31'd0, dmem_we}, {31'd0, isWr});
        if (isWr) checkOutput("bus_wdata", dmem_wdata, expWd);
      end
      dmem_gnt = dmem_req && !gnted && (reqCnt == gd);
      if (dmem_req) reqCnt++;
      if (gnted) respCnt++;
      dmem_rvalid = gnted && !isWr && (respCnt == rd);
      if (dmem_gnt) gnted = 1;
      @(negedge clk);
    end
    dmem_gnt = 1'b0;
    dmem_rvalid = 1'b0;

    checkOutput("done_cycle", doneCyc, expCyc);
    checkOutput("err", {31'd0, gotErr}, {31'd0, expErr});
    if (!isWr || expErr) checkOutput("read_data", gotRd, expRd);
    checkOutput("req_issued", {31'd0, reqSeen}, {31'd0, !mis});
    checkOutput("busy_in_flight", {31'd0, busyBad}, 0);
    checkOutput("busy_at_done", {31'd0, gotBusy}, 0);
    checkOutput("req_at_done", {31'd0, gotReq}, 0);
    @(negedge clk);
    checkOutput("done_pulse", {31'd0, MemDoneM}, 0);
  endtask

  initial begin
    bit isWr;
    bit alsoRd;
    bit sgn;
    logic [1:0] sz;
    logic [31:0] addr;
    int p;
    int q;
    int gd;
    int rd;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, MemBusyM}, 0);
    checkOutput("rst_done", {31'd0, MemDoneM}, 0);
    checkOutput("rst_err", {31'd0, MemErrM}, 0);
    checkOutput("rst_rdata", ReadDataM, 0);
    checkOutput("rst_req", {31'd0, dmem_req}, 0);
    checkOutput("rst_bus", {dmem_be, 27'd0, dmem_we} | dmem_addr | dmem_wdata, 0);
    rst = 1'b1;
    @(negedge clk);

    // Store byte at 0x103, signed/unsigned half loads, misaligned word, timeout
    applyStimulus(1, 0, 32'h103, 32'h1234_56AB, 2'b00, 0, 0, 1, 32'h0);
    applyStimulus(0, 1, 32'h202, 32'h0, 2'b01, 1, 0, 1, 32'h8001_1234);
    applyStimulus(0, 1, 32'h202, 32'h0, 2'b01, 0, 0, 1, 32'h8001_1234);
    applyStimulus(0, 1, 32'h006, 32'h0, 2'b10, 0, 0, 1, 32'hCAFE_F00D);
    applyStimulus(0, 1, 32'h040, 32'h0, 2'b10, 0, MAX_WAIT + 1, 1, 32'h1111_2222);

    // Late rvalid after the timeout must be ignored
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checkOutput("late_rvalid_done", {31'd0, MemDoneM}, 0);
    checkOutput("late_rvalid_rdata", ReadDataM, 0);
    checkOutput("late_rvalid_busy", {31'd0, MemBusyM}, 0);

    // Back-to-back store then load with grant always high
    @(negedge clk);
    MemWriteE = 1'b1; MemReadE = 1'b0; ALUResultE = 32'h103; WriteDataE = 32'h1234_56AB;
    MemSizeE = 2'b00; MemSignedE = 1'b0; dmem_gnt = 1'b1;
    @(negedge clk);
    checkOutput("b2b_req", {31'd0, dmem_req}, 1);
    checkOutput("b2b_be", {28'd0, dmem_be}, 32'h8);
    checkOutput("b2b_wdata", dmem_wdata, 32'hABAB_ABAB);
    checkOutput("b2b_addr", dmem_addr, 32'h100);
    MemWriteE = 1'b0; MemReadE = 1'b1; ALUResultE = 32'h202; MemSizeE = 2'b01; MemSignedE = 1'b1;
    @(negedge clk);
    checkOutput("b2b_done1", {31'd0, MemDoneM}, 1);
    checkOutput("b2b_busy_done", {31'd0, MemBusyM}, 0);
    @(negedge clk);
    MemReadE = 1'b0;
    checkOutput("b2b_busy_req2", {31'd0, MemBusyM}, 1);
    checkOutput("b2b_req2", {31'd0, dmem_req}, 1);
    checkOutput("b2b_we2", {31'd0, dmem_we}, 0);
    @(negedge clk);
    dmem_gnt = 1'b0;
    checkOutput("b2b_busy_resp", {31'd0, MemBusyM}, 1);
    checkOutput("b2b_req_resp", {31'd0, dmem_req}, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_1234;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checkOutput("b2b_done2", {31'd0, MemDoneM}, 1);
    checkOutput("b2b_rdata", ReadDataM, 32'hFFFF_8001);
    @(negedge clk);

    // Reset while in REQ drops the request without a clock edge
    MemReadE = 1'b1; ALUResultE = 32'h300; MemSizeE = 2'b10;
    @(negedge clk);
    MemReadE = 1'b0;
    checkOutput("rreq_req_before", {31'd0, dmem_req}, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rreq_req_after", {31'd0, dmem_req}, 0);
    checkOutput("rreq_busy_after", {31'd0, MemBusyM}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Reset while in RESP; a following rvalid must not retire anything
    MemReadE = 1'b1; ALUResultE = 32'h304; MemSizeE = 2'b10; dmem_gnt = 1'b1;
    @(negedge clk);
    MemReadE = 1'b0;
    @(negedge clk);
    dmem_gnt = 1'b0;
    checkOutput("rresp_busy_before", {31'd0, MemBusyM}, 1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rresp_busy_after", {31'd0, MemBusyM}, 0);
    checkOutput("rresp_req_after", {31'd0, dmem_req}, 0);
    checkOutput("rresp_rdata_after", ReadDataM, 0);
    @(negedge clk);
    rst = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    checkOutput("rresp_no_done", {31'd0, MemDoneM}, 0);
    checkOutput("rresp_no_rdata", ReadDataM, 0);
    @(negedge clk);

    // Randomized accesses, biased toward aligned addresses and short waits,
    // with occasional boundary and timeout wait lengths
    for (int n = 0; n < 60; n++) begin
      isWr   = 1'($urandom % 2);
      alsoRd = 1'($urandom % 2);
      sgn    = 1'($urandom % 2);
      sz     = 2'($urandom % 4);
      addr   = $urandom;
      if (($urandom % 3) != 0) begin
        if (sz == 2'b00)      addr = addr;
        else if (sz == 2'b01) addr = addr & 32'hFFFF_FFFE;
        else                  addr = addr & 32'hFFFF_FFFC;
      end
      p  = int'($urandom % 12);
      gd = (p == 0) ? MAX_WAIT + 1 : (p == 1) ? MAX_WAIT - 1 : int'($urandom % 4);
      q  = int'($urandom % 12);
      rd = (q == 0) ? MAX_WAIT + 2 : (q == 1) ? MAX_WAIT : 1 + int'($urandom % 3);
      applyStimulus(isWr, alsoRd, addr, $urandom, sz, sgn, gd, rd, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
